try1: RTL and testbench
=======================

TRY1 -- requirements
Module: try1

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive synchronized samples needed to accept a new input code; legal range 1..255.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 Port XLXN_42, input, 1 bit: code bit 0 (LSB), asynchronous to clk.
REQ-005 Port XLXN_46, input, 1 bit: code bit 1 (MSB), asynchronous to clk.
REQ-006 Port XLXN_47, output, 1 bit: high when accepted code = 0.
REQ-007 Port XLXN_48, output, 1 bit: high when accepted code = 1.
REQ-008 Port XLXN_49, output, 1 bit: high when accepted code = 2.
REQ-009 Port XLXN_50, output, 1 bit: high when accepted code = 3.

Function
REQ-010 Raw code {XLXN_46, XLXN_42} SHALL pass through a two-flop synchronizer per bit; the second-stage value is the sampled code.
REQ-011 The block SHALL hold a previous-sample register and an 8-bit stability counter.
REQ-012 When the sampled code differs from the previous sample, the counter SHALL clear to 0.
REQ-013 When the sampled code equals the previous sample and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 The counter SHALL saturate at STABLE_CYCLES-1 and never wrap.
REQ-015 When the counter equals STABLE_CYCLES-1 and the sample is unchanged, the sampled code SHALL load into the accepted-code register.
REQ-016 Outputs SHALL be registered one-hot decodes of the accepted code: exactly one output high at all times, including reset.
REQ-017 Total latency from the first clk edge sampling a new stable raw code to the outputs changing SHALL be STABLE_CYCLES+3 edges (7 at default).
REQ-018 A raw code held for fewer than STABLE_CYCLES+1 consecutive synchronized samples SHALL NOT change the outputs.
REQ-019 Re-accepting the already-accepted code SHALL leave the outputs unchanged, with no glitch.
REQ-020 With STABLE_CYCLES=1, any code unchanged for two consecutive samples SHALL be accepted.

Reset
REQ-021 rst_n low SHALL immediately clear the synchronizers, previous sample, counter and accepted code to 0, independent of clk.
REQ-022 During reset, outputs SHALL be XLXN_47=1 and XLXN_48=XLXN_49=XLXN_50=0.
REQ-023 Reset asserted mid-count SHALL discard the pending code.
REQ-024 After rst_n deasserts, a nonzero code SHALL need the full REQ-017 latency before reaching the outputs.

Structure
REQ-025 A shared package SHALL hold the code width constant (2), the counter width constant (8) and the one-hot decode function.
REQ-026 One sub-module, try1_sync2 (two-flop synchronizer, width-parameterized, async active-low reset), SHALL be used; all other logic stays in try1.

Verification
REQ-027 Reset scenario: hold rst_n=0 with inputs=11 -> outputs 0001 (XLXN_47 high) throughout, regardless of clk.
REQ-028 Latency scenario: release reset, then drive XLXN_46=1, XLXN_42=0 and hold -> XLXN_49 rises exactly 7 edges after first sampling at default, and the other outputs are low.
REQ-029 Glitch-rejection scenario: from code 0, pulse code 3 for 3 clk cycles, then return to 0 -> outputs remain 0001 throughout.
REQ-030 Sweep scenario: step codes 0,1,2,3 in turn, each held 20 cycles -> outputs 0001, 0010, 0100, 1000 in order; a one-hot check passes every cycle.
REQ-031 Mid-count reset scenario: drive code 3, then assert rst_n=0 at edge 4 -> outputs go to 0001 asynchronously, and code 3 appears only 7 edges after reset release.
REQ-032 Parameter scenario: set STABLE_CYCLES=1 and step the code from 0 to 2 -> XLXN_49 rises 4 edges after the code is first sampled.

Source files
------------

// File: rtl/try1_pkg.sv
// Shared types and helpers for the try1 code decoder.
// Holds the code/counter widths and the one-hot decode.
package try1_pkg;

  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;
  localparam int OH_W   = 1 << CODE_W;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [OH_W-1:0]   oh_t;

  function automatic oh_t onehot(code_t c);
    oh_t r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/try1_if.sv
// Code-in / one-hot-out bundle for the try1 decoder.
// Master drives the raw code, slave returns the decode.
interface try1_if;
  import try1_pkg::*;

  code_t code;
  oh_t   oh;

  modport master (output code, input oh);
  modport slave  (input code, output oh);

endinterface

// File: rtl/try1_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Width-parameterized, async active-low reset to zero.
module try1_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Two back-to-back stages to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/try1.sv
// Debounced 2-bit code to registered one-hot decoder.
// A code is accepted after STABLE_CYCLES+1 equal samples.
module try1
  import try1_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic XLXN_42,
  input  logic XLXN_46,
  output logic XLXN_47,
  output logic XLXN_48,
  output logic XLXN_49,
  output logic XLXN_50
);

  localparam cnt_t LAST = cnt_t'(STABLE_CYCLES - 1);

  code_t raw;
  code_t samp;
  code_t prev_q, prev_d;
  code_t acc_q, acc_d;
  cnt_t  cnt_q, cnt_d;
  oh_t   oh_q, oh_d;

  assign raw = {XLXN_46, XLXN_42};

  try1_sync2 #(
    .W(CODE_W)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (raw),
    .q_o  (samp)
  );

  // Stability count; accept and decode in the same
  // edge so the outputs carry no extra stage.
  always_comb begin
    prev_d = samp;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (samp != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q < LAST) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else begin
      acc_d = samp;
    end
    oh_d = onehot(acc_d);
  end

  // State registers; reset forces code 0 decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      oh_q   <= onehot('0);
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      oh_q   <= oh_d;
    end
  end

  assign XLXN_47 = oh_q[0];
  assign XLXN_48 = oh_q[1];
  assign XLXN_49 = oh_q[2];
  assign XLXN_50 = oh_q[3];

endmodule

// File: tb/tb_try1.sv
// Scoreboard bench for try1: default and STABLE_CYCLES=1.
// Expected output changes are queued with their edge.
module tb_try1;
  import try1_pkg::*;

  typedef struct {
    logic [3:0] v;
    int         e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst1_n = 1'b1;
  logic [3:0] o4;
  logic [3:0] o1;
  int edge_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q4[$];
  exp_t q1[$];

  try1_if bus ();

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  try1 #(
    .STABLE_CYCLES(4)
  ) u4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .XLXN_42(bus.code[0]),
    .XLXN_46(bus.code[1]),
    .XLXN_47(o4[0]),
    .XLXN_48(o4[1]),
    .XLXN_49(o4[2]),
    .XLXN_50(o4[3])
  );

  try1 #(
    .STABLE_CYCLES(1)
  ) u1 (
    .clk    (clk),
    .rst_n  (rst1_n),
    .XLXN_42(bus.code[0]),
    .XLXN_46(bus.code[1]),
    .XLXN_47(o1[0]),
    .XLXN_48(o1[1]),
    .XLXN_49(o1[2]),
    .XLXN_50(o1[3])
  );

  assign bus.oh = o4;

  task automatic chk(string nm, logic [3:0] act,
                     logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask

  task automatic push4(logic [3:0] v, int e);
    exp_t x;
    x.v = v;
    x.e = e;
    q4.push_back(x);
  endtask

  task automatic push1(logic [3:0] v, int e);
    exp_t x;
    x.v = v;
    x.e = e;
    q1.push_back(x);
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: one-hot every cycle, pop on each change.
  initial begin
    logic [3:0] l4;
    logic [3:0] l1;
    exp_t x;
    l4 = 4'b0001;
    l1 = 4'b0001;
    #2;
    forever begin
      @(negedge clk);
      n_chk++;
      if (!$onehot(o4) || !$onehot(o1)) begin
        n_fail++;
        $display("FAIL onehot: got %b / %b want one bit",
                 o4, o1);
      end
      if (o4 !== l4) begin
        n_chk++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL chg4: got %b at edge %0d want no change",
                   o4, edge_n);
        end else begin
          x = q4.pop_front();
          if (o4 !== x.v || edge_n != x.e) begin
            n_fail++;
            $display("FAIL chg4: got %b at edge %0d want %b at %0d",
                     o4, edge_n, x.v, x.e);
          end
        end
        l4 = o4;
      end
      if (o1 !== l1) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL chg1: got %b at edge %0d want no change",
                   o1, edge_n);
        end else begin
          x = q1.pop_front();
          if (o1 !== x.v || edge_n != x.e) begin
            n_fail++;
            $display("FAIL chg1: got %b at edge %0d want %b at %0d",
                     o1, edge_n, x.v, x.e);
          end
        end
        l1 = o1;
      end
    end
  end

  // Directed stimulus.
  initial begin
    bus.code = 2'b11;
    #1;
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    #1;
    chk("rst_noclk4", o4, 4'b0001);
    chk("rst_noclk1", o1, 4'b0001);
    repeat (5) begin
      @(negedge clk);
      chk("rst_hold4", o4, 4'b0001);
      chk("rst_hold1", o1, 4'b0001);
    end

    // Release reset and present code 2.
    @(negedge clk);
    rst_n    = 1'b1;
    bus.code = 2'b10;
    push4(4'b0100, edge_n + 7);
    wait_n(15);
    chk("lat_code2", o4, 4'b0100);

    // Back to 0, then a 3-cycle glitch of code 3.
    bus.code = 2'b00;
    push4(4'b0001, edge_n + 7);
    wait_n(12);
    bus.code = 2'b11;
    wait_n(3);
    bus.code = 2'b00;
    wait_n(15);
    chk("glitch", o4, 4'b0001);

    // Sweep 0..3, 20 cycles each.
    for (int c = 0; c < 4; c++) begin
      bus.code = 2'(c);
      if (c != 0)
        push4(4'b0001 << c, edge_n + 7);
      wait_n(20);
      chk("sweep", o4, 4'b0001 << c);
    end

    // Settle on code 1, then reset mid-count of code 3.
    bus.code = 2'b01;
    push4(4'b0010, edge_n + 7);
    wait_n(20);
    bus.code = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    push4(4'b0001, edge_n);
    #1;
    chk("midrst_async", o4, 4'b0001);
    wait_n(3);
    rst_n = 1'b1;
    push4(4'b1000, edge_n + 7);
    wait_n(6);
    chk("midrst_hold", o4, 4'b0001);
    wait_n(9);
    chk("midrst_code3", o4, 4'b1000);

    // STABLE_CYCLES=1 instance: step 0 -> 2.
    bus.code = 2'b00;
    rst1_n   = 1'b1;
    push4(4'b0001, edge_n + 7);
    wait_n(10);
    bus.code = 2'b10;
    push4(4'b0100, edge_n + 7);
    push1(4'b0100, edge_n + 4);
    wait_n(12);
    chk("p1_code2", o1, 4'b0100);
    chk("p4_code2", o4, 4'b0100);

    n_chk++;
    if (q4.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL pending: got %0d/%0d left want 0/0",
               q4.size(), q1.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
